// File: rtl/enemy_unit.sv
`default_nettype none
// ============================================================================
// Module   : enemy_unit
// Purpose  : One enemy sprite. Follows a waypoint path read from an external
//            ROM, draws/erases itself on frame ticks, absorbs tower hits and
//            reports arrival (game_over) or destruction.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_unit #(
    parameter int         SPRITE_W   = 4,
    parameter int         SPRITE_H   = 4,
    parameter int         STEP       = 1,
    parameter int         HEALTH     = 3,
    parameter int         NUM_WP     = 8,
    parameter int         DELAY_W    = 8,
    parameter logic [8:0] CAR_COLOUR = 9'h1C0,
    parameter logic [8:0] BG_COLOUR  = 9'h000,
    parameter int         WP_W       = $clog2(NUM_WP)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               initiate,
    input  logic               enable_draw,
    input  logic               hit,
    input  logic [DELAY_W-1:0] delay_frames,
    output logic [WP_W-1:0]    wp_addr,
    input  logic [7:0]         wp_x,
    input  logic [6:0]         wp_y,
    output logic               vga_write_en,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [8:0]         vga_colour,
    output logic [7:0]         car_x,
    output logic [6:0]         car_y,
    output logic               car_alive,
    output logic               car_done,
    output logic               destroyed,
    output logic               game_over,
    output logic [7:0]         health_left
);

    localparam int              PX_W        = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int              PY_W        = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [PX_W-1:0] PX_LAST     = PX_W'(SPRITE_W - 1);
    localparam logic [PY_W-1:0] PY_LAST     = PY_W'(SPRITE_H - 1);
    localparam logic [7:0]      STEP_X      = (STEP > 255) ? 8'd255 : 8'(STEP);
    localparam logic [6:0]      STEP_Y      = (STEP > 127) ? 7'd127 : 7'(STEP);
    localparam logic [WP_W-1:0] WP_LAST     = WP_W'(NUM_WP - 1);
    localparam logic [7:0]      HEALTH_INIT = 8'(HEALTH);

    typedef enum logic [3:0] {
        S_IDLE, S_DELAY, S_DRAW, S_WAIT, S_ERASE, S_MOVE, S_KILL, S_DEAD, S_ARRIVED
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WP_W-1:0]    wp_idx;
    logic [DELAY_W-1:0] delay_cnt;
    logic [PX_W-1:0]    px;
    logic [PY_W-1:0]    py;

    logic               sweeping;
    logic               sweep_last;
    logic               hit_ok;
    logic [7:0]         health_nxt;
    logic               kill;
    logic [7:0]         dx_mag;
    logic [6:0]         dy_mag;
    logic [7:0]         step_x;
    logic [6:0]         step_y;
    logic [7:0]         new_x;
    logic [6:0]         new_y;
    logic               at_wp;
    logic               last_wp;

    // Derived datapath terms: liveness, damage outcome and the one-step move target
    always_comb begin
        car_alive  = (state == S_DELAY) || (state == S_DRAW) || (state == S_WAIT) ||
                     (state == S_ERASE) || (state == S_MOVE);
        sweeping   = (state == S_DRAW) || (state == S_ERASE) || (state == S_KILL);
        sweep_last = (px == PX_LAST) && (py == PY_LAST);
        // The kill decision uses health after this cycle's hit, so a hit in MOVE beats arrival
        hit_ok     = hit && car_alive && (health_left != 8'd0);
        health_nxt = hit_ok ? (health_left - 8'd1) : health_left;
        kill       = (health_nxt == 8'd0);
        dx_mag     = (car_x > wp_x) ? (car_x - wp_x) : (wp_x - car_x);
        dy_mag     = (car_y > wp_y) ? (car_y - wp_y) : (wp_y - car_y);
        step_x     = (dx_mag < STEP_X) ? dx_mag : STEP_X;
        step_y     = (dy_mag < STEP_Y) ? dy_mag : STEP_Y;
        new_x      = car_x;
        new_y      = car_y;
        if (car_x != wp_x) begin
            new_x = (car_x > wp_x) ? (car_x - step_x) : (car_x + step_x);
        end else begin
            new_y = (car_y > wp_y) ? (car_y - step_y) : (car_y + step_y);
        end
        at_wp   = (new_x == wp_x) && (new_y == wp_y);
        last_wp = (wp_idx == WP_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the pixel-port / status outputs
    always_comb begin
        next_state   = state;
        vga_write_en = sweeping;
        vga_x        = sweeping ? (car_x + 8'(px)) : 8'd0;
        vga_y        = sweeping ? (car_y + 7'(py)) : 7'd0;
        vga_colour   = (state == S_DRAW) ? CAR_COLOUR : (sweeping ? BG_COLOUR : 9'd0);
        car_done     = (state == S_DRAW) && sweep_last;
        destroyed    = (state == S_DEAD);
        // The ROM must present waypoint 0 while a start is pending
        wp_addr      = ((state == S_IDLE) || (state == S_ARRIVED)) ? '0 : wp_idx;
        case (state)
            S_IDLE, S_ARRIVED: if (initiate) next_state = S_DELAY;
            S_DELAY: begin
                if (kill)                            next_state = S_DEAD;
                else if (delay_cnt == delay_frames)  next_state = S_DRAW;
            end
            S_DRAW:  if (sweep_last) next_state = kill ? S_KILL : S_WAIT;
            S_WAIT: begin
                if (kill)             next_state = S_KILL;
                else if (enable_draw) next_state = S_ERASE;
            end
            S_ERASE: if (sweep_last) next_state = kill ? S_DEAD : S_MOVE;
            S_MOVE: begin
                if (kill)                  next_state = S_DEAD;
                else if (at_wp && last_wp) next_state = S_ARRIVED;
                else                       next_state = S_DRAW;
            end
            S_KILL:  if (sweep_last) next_state = S_DEAD;
            S_DEAD:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Row-major pixel sweep counters shared by DRAW, ERASE and KILL
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (sweeping && !sweep_last) begin
            if (px == PX_LAST) begin
                px <= '0;
                py <= py + PY_W'(1);
            end else begin
                px <= px + PX_W'(1);
            end
        end else begin
            px <= '0;
            py <= '0;
        end
    end

    // Position, health, waypoint index, delay counter and arrival flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            car_x       <= 8'd0;
            car_y       <= 7'd0;
            health_left <= 8'd0;
            wp_idx      <= '0;
            delay_cnt   <= '0;
            game_over   <= 1'b0;
        end else begin
            health_left <= health_nxt;
            case (state)
                S_IDLE, S_ARRIVED: begin
                    if (initiate) begin
                        car_x       <= wp_x;
                        car_y       <= wp_y;
                        wp_idx      <= WP_W'(1);
                        health_left <= HEALTH_INIT;
                        delay_cnt   <= '0;
                        game_over   <= 1'b0;
                    end
                end
                S_DELAY: begin
                    if (enable_draw && (delay_cnt != delay_frames)) begin
                        delay_cnt <= delay_cnt + DELAY_W'(1);
                    end
                end
                S_MOVE: begin
                    if (!kill) begin
                        car_x <= new_x;
                        car_y <= new_y;
                        if (at_wp && last_wp) begin
                            game_over <= 1'b1;
                        end else if (at_wp) begin
                            wp_idx <= wp_idx + WP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_unit
// Purpose  : Scoreboard bench for enemy_unit. A path-level reference model
//            predicts the pixel-write / destroyed event stream; a monitor
//            compares it against what the DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_unit;

    localparam int         SW   = 3;
    localparam int         SH   = 2;
    localparam int         STP  = 3;
    localparam int         HP   = 3;
    localparam int         NWP  = 4;
    localparam int         DW   = 8;
    localparam int         NPIX = SW * SH;
    localparam logic [8:0] CARC = 9'h1C0;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          initiate = 1'b0;
    logic          man_tick = 1'b0;
    logic          rand_tick = 1'b0;
    logic          hit = 1'b0;
    logic [DW-1:0] delay_frames = '0;
    logic          enable_draw;
    logic [1:0]    wp_addr;
    logic [7:0]    wp_x, vga_x, car_x;
    logic [6:0]    wp_y, vga_y, car_y;
    logic [8:0]    vga_colour;
    logic [7:0]    health_left;
    logic          vga_write_en, car_alive, car_done, destroyed, game_over;

    logic [7:0]    rom_x [NWP];
    logic [6:0]    rom_y [NWP];
    int            wx [NWP];
    int            wy [NWP];
    int            pos_x [$];
    int            pos_y [$];
    bit            tick_on = 1'b0;
    int            errors = 0;
    int            checks = 0;

    typedef struct {
        bit         is_kill;
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] col;
        bit         done;
    } ev_t;
    ev_t exp_q [$];

    assign enable_draw = man_tick | rand_tick;
    assign wp_x = rom_x[wp_addr];
    assign wp_y = rom_y[wp_addr];

    enemy_unit #(
        .SPRITE_W(SW), .SPRITE_H(SH), .STEP(STP), .HEALTH(HP),
        .NUM_WP(NWP), .DELAY_W(DW), .CAR_COLOUR(CARC), .BG_COLOUR(9'h000)
    ) dut (
        .clk(clk), .resetn(resetn), .initiate(initiate), .enable_draw(enable_draw),
        .hit(hit), .delay_frames(delay_frames), .wp_addr(wp_addr), .wp_x(wp_x),
        .wp_y(wp_y), .vga_write_en(vga_write_en), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .car_x(car_x), .car_y(car_y), .car_alive(car_alive),
        .car_done(car_done), .destroyed(destroyed), .game_over(game_over),
        .health_left(health_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({vga_write_en, vga_x, vga_y, vga_colour, car_x, car_y, health_left,
                    wp_addr, car_alive, car_done, destroyed, game_over});
    endfunction

    // Monitor: every write or destroyed pulse consumes one predicted event
    always @(negedge clk) begin : monitor
        ev_t e;
        if (resetn) begin
            if (vga_write_en || destroyed) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'({vga_write_en, destroyed}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_kill)
                        check("destroyed_event", 64'({vga_write_en, destroyed}), 64'(2'b01));
                    else
                        check("pixel", 64'({vga_write_en, destroyed, vga_x, vga_y, vga_colour, car_done}),
                              64'({1'b1, 1'b0, e.x, e.y, e.col, e.done}));
                end
            end else if (car_done) begin
                check("car_done_without_write", 64'(car_done), 64'(0));
            end
        end
    end

    // Random frame ticks while enabled
    initial forever begin
        @(posedge clk); #1;
        rand_tick = tick_on && ($urandom_range(0, 7) == 0);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic tick1();
        man_tick = 1'b1; cyc(); man_tick = 1'b0;
    endtask

    task automatic hits(input int n);
        hit = 1'b1; repeat (n) cyc(); hit = 1'b0;
    endtask

    task automatic start(input int d);
        delay_frames = DW'(d); initiate = 1'b1; cyc(); initiate = 1'b0;
    endtask

    task automatic stop_ticks();
        tick_on = 1'b0; cyc(); cyc();
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return car_done;
            1:       return vga_write_en;
            default: return game_over;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int bound, input string name);
        int n;
        n = 0;
        while (!sig(w) && n < bound) begin cyc(); n++; end
        check(name, 64'(sig(w)), 64'(1));
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin cyc(); n++; end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic gen_path();
        int dx, dy;
        wx[0] = $urandom_range(40, 150);
        wy[0] = $urandom_range(40, 80);
        for (int i = 1; i < NWP; i++) begin
            do begin
                dx = int'($urandom_range(0, 24)) - 12;
                dy = int'($urandom_range(0, 24)) - 12;
            end while (dx == 0 && dy == 0);
            wx[i] = wx[i-1] + dx;
            wy[i] = wy[i-1] + dy;
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < NWP; i++) begin
            rom_x[i] = 8'(wx[i]);
            rom_y[i] = 7'(wy[i]);
        end
    endtask

    // Positions at which the sprite is drawn: walk the path, x first then y,
    // at most STP px per frame, until the final waypoint is reached
    task automatic build_positions();
        int x, y, k, d, s;
        pos_x.delete(); pos_y.delete();
        x = wx[0]; y = wy[0]; k = 1;
        pos_x.push_back(x); pos_y.push_back(y);
        forever begin
            if (x != wx[k]) begin
                d = (wx[k] > x) ? wx[k] - x : x - wx[k];
                s = (d < STP) ? d : STP;
                x = (wx[k] > x) ? x + s : x - s;
            end else begin
                d = (wy[k] > y) ? wy[k] - y : y - wy[k];
                s = (d < STP) ? d : STP;
                y = (wy[k] > y) ? y + s : y - s;
            end
            if (x == wx[k] && y == wy[k]) begin
                if (k == NWP - 1) break;
                k++;
            end
            pos_x.push_back(x); pos_y.push_back(y);
        end
    endtask

    task automatic push_sweep(input int x, input int y, input logic [8:0] col, input bit is_draw);
        ev_t e;
        for (int yy = 0; yy < SH; yy++) begin
            for (int xx = 0; xx < SW; xx++) begin
                e.is_kill = 1'b0;
                e.x       = 8'(x + xx);
                e.y       = 7'(y + yy);
                e.col     = col;
                e.done    = is_draw && (yy == SH - 1) && (xx == SW - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_frames(input int n);
        for (int i = 0; i < n; i++) begin
            push_sweep(pos_x[i], pos_y[i], CARC, 1'b1);
            push_sweep(pos_x[i], pos_y[i], 9'h000, 1'b0);
        end
    endtask

    task automatic push_destroyed();
        ev_t e;
        e.is_kill = 1'b1; e.x = '0; e.y = '0; e.col = '0; e.done = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_final_pos(input string name);
        check(name, 64'({car_x, car_y}), 64'({8'(wx[NWP-1]), 7'(wy[NWP-1])}));
    endtask

    initial begin
        int d, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs_vec(), 64'(0));
        cyc(); resetn = 1'b1; cyc();

        // Asynchronous reset in the middle of a draw sweep
        gen_path(); load_rom(); build_positions(); push_frames(1);
        start(0);
        wait_sig(1, 50, "reset_test_first_write");
        cyc(); cyc();
        resetn = 1'b0; exp_q.delete();
        @(negedge clk);
        check("reset_mid_draw", outs_vec(), 64'(0));
        cyc(); resetn = 1'b1; cyc();

        // Directed path: delay of two ticks, partial final steps, arrival
        wx = '{10, 12, 12, 7}; wy = '{20, 20, 26, 26};
        load_rom(); build_positions(); push_frames(pos_x.size());
        start(2);
        tick1();
        repeat (3) begin check("no_draw_before_2nd_tick", 64'(vga_write_en), 64'(0)); cyc(); end
        tick1();
        check("no_draw_cycle_after_2nd_tick", 64'(vga_write_en), 64'(0));
        cyc();
        check("first_draw_after_2nd_tick", 64'({vga_write_en, car_x, car_y}), 64'({1'b1, 8'd10, 7'd20}));
        tick_on = 1'b1;
        wait_sig(2, 5000, "directed_arrival");
        check_final_pos("directed_final_pos");
        check("arrived_status", 64'({car_alive, health_left}), 64'({1'b0, 8'(HP)}));
        hits(1);
        repeat (40) cyc();
        check("game_over_held", 64'(game_over), 64'(1));
        check("hit_ignored_when_arrived", 64'(health_left), 64'(HP));
        drain(10);

        // Random paths, each restarted from ARRIVED
        repeat (3) begin
            stop_ticks();
            gen_path(); load_rom(); build_positions(); push_frames(pos_x.size());
            start($urandom_range(0, 3));
            check("restart_clears_game_over", 64'(game_over), 64'(0));
            check("restart_at_wp0", 64'({car_x, car_y}), 64'({8'(wx[0]), 7'(wy[0])}));
            tick_on = 1'b1;
            wait_sig(2, 5000, "random_arrival");
            check_final_pos("random_final_pos");
            drain(10);
        end
        stop_ticks();

        // Kill while waiting out the start delay: nothing drawn
        gen_path(); load_rom(); push_destroyed();
        start(5); cyc(); hits(3);
        drain(50);
        check("delay_kill_status", 64'({car_alive, game_over, health_left}), 64'(0));
        hits(1); cyc();
        check("hit_ignored_when_idle", 64'(health_left), 64'(0));

        // Kill during the draw sweep, with one extra hit at zero health
        gen_path(); load_rom(); build_positions(); push_frames(1); push_destroyed();
        start(0);
        wait_sig(1, 50, "draw_kill_first_write");
        cyc(); hits(4);
        drain(100);
        check("health_saturates_at_zero", 64'(health_left), 64'(0));

        // Kill in WAIT after a random number of frames
        repeat (2) begin
            gen_path(); load_rom(); build_positions();
            k = $urandom_range(1, pos_x.size());
            push_frames(k); push_destroyed();
            start(0);
            for (int f = 1; f <= k; f++) begin
                wait_sig(0, 200, "wait_kill_car_done");
                cyc();
                if (f < k) tick1();
                else hits(3);
            end
            drain(100);
            check("wait_kill_pos", 64'({car_alive, car_x, car_y}),
                  64'({1'b0, 8'(pos_x[k-1]), 7'(pos_y[k-1])}));
        end

        // Kill during the erase sweep: erase completes, no move
        gen_path(); load_rom(); build_positions(); push_frames(1); push_destroyed();
        start(0);
        wait_sig(0, 100, "erase_kill_car_done");
        cyc(); tick1(); hits(3);
        drain(100);
        check("erase_kill_no_move", 64'({car_x, car_y}), 64'({8'(pos_x[0]), 7'(pos_y[0])}));

        // Final hit lands in the arriving MOVE cycle: kill wins
        gen_path(); load_rom(); build_positions();
        d = pos_x.size();
        push_frames(d); push_destroyed();
        start(0);
        for (int f = 1; f <= d; f++) begin
            wait_sig(0, 200, "move_kill_car_done");
            cyc();
            if (f == 1) begin
                hits(2);
                check("health_after_two_hits", 64'(health_left), 64'(HP - 2));
            end
            tick1();
            if (f == d) begin
                repeat (NPIX) cyc();
                hits(1);
            end
        end
        drain(50);
        repeat (10) cyc();
        check("kill_beats_arrival", 64'({game_over, car_alive, health_left}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
